// File: rtl/mmcm_drp_sequencer_if.sv
// Control and DRP/MMCM pin bundle for the MMCM output-divider reconfiguration sequencer.
// The master side is the sequencer; the slave side is the requester plus the MMCM primitive.
interface mmcm_drp_sequencer_if;
    logic        REQ;
    logic [5:0]  DIV;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [6:0]  DADDR;
    logic [15:0] DI;
    logic [15:0] DO;
    logic        DEN;
    logic        DWE;
    logic        DRDY;
    logic        MMCM_RST;
    logic        LOCKED;

    modport master (
        input  REQ, DIV, DO, DRDY, LOCKED,
        output BUSY, DONE, ERR, DADDR, DI, DEN, DWE, MMCM_RST
    );

    modport slave (
        output REQ, DIV, DO, DRDY, LOCKED,
        input  BUSY, DONE, ERR, DADDR, DI, DEN, DWE, MMCM_RST
    );
endinterface

// File: rtl/mmcm_drp_sequencer.sv
// Reprograms one MMCM output divider: hold MMCM in reset, RMW ClkReg1/ClkReg2 over DRP, release, wait for lock.
// Latency: DRP accesses wait on DRDY (bounded); DONE/ERR are registered one-cycle pulses; REQ while busy is dropped.
module mmcm_drp_sequencer #(
    parameter logic [6:0] REG1_ADDR    = 7'h0C,
    parameter logic [6:0] REG2_ADDR    = 7'h0D,
    parameter int         DRDY_TIMEOUT = 64,
    parameter int         LOCK_TIMEOUT = 65535
) (
    input logic                  CLK_100,
    input logic                  RST,
    mmcm_drp_sequencer_if.master bus
);
    localparam int CNT_MAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DRDY_LAST  = CNT_W'(DRDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_BLANK = CNT_W'(4);

    typedef enum logic [3:0] {
        IDLE, ASRT, RD1, WR1W, WR1, WD1, RD2, WR2W, WR2, WD2, RLS, LCK
    } state_t;

    state_t            state, state_nxt, wait_exit;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [5:0]        div_q, div_nxt;
    logic [15:0]       rd_q, rd_nxt;
    logic              done_q, done_nxt;
    logic              err_q, err_nxt;
    logic              lock_meta, lock_s;

    logic [5:0]        hi, lo;
    logic              edge_bit, nocnt;
    logic [15:0]       reg1_new, reg2_new;

    // Divider split: LO takes the odd extra count, EDGE flags the half-cycle, NOCNT bypasses for divide-by-1.
    assign hi       = {1'b0, div_q[5:1]};
    assign lo       = div_q - hi;
    assign edge_bit = div_q[0];
    assign nocnt    = (div_q == 6'd1);
    assign reg1_new = (rd_q & 16'h1000) | {4'b0000, hi, lo};
    assign reg2_new = (rd_q & 16'hFF00) | {8'h00, edge_bit, nocnt, 6'd0};

    assign bus.BUSY = (state != IDLE);
    assign bus.DONE = done_q;
    assign bus.ERR  = err_q;

    always_ff @(posedge CLK_100 or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            div_q     <= '0;
            rd_q      <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            div_q     <= div_nxt;
            rd_q      <= rd_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
            lock_meta <= bus.LOCKED;
            lock_s    <= lock_meta;
        end
    end

    always_comb begin
        case (state)
            WR1W:    wait_exit = WR1;
            WD1:     wait_exit = RD2;
            WR2W:    wait_exit = WR2;
            default: wait_exit = RLS;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        div_nxt      = div_q;
        rd_nxt       = rd_q;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        bus.DEN      = 1'b0;
        bus.DWE      = 1'b0;
        bus.DADDR    = '0;
        bus.DI       = '0;
        bus.MMCM_RST = 1'b0;

        case (state)
            IDLE: begin
                if (bus.REQ) begin
                    if (bus.DIV == 6'd0) begin
                        err_nxt = 1'b1;
                    end else begin
                        div_nxt   = bus.DIV;
                        state_nxt = ASRT;
                    end
                end
            end
            ASRT: begin
                bus.MMCM_RST = 1'b1;
                state_nxt    = RD1;
            end
            RD1: begin
                bus.MMCM_RST = 1'b1;
                bus.DEN      = 1'b1;
                bus.DADDR    = REG1_ADDR;
                cnt_nxt      = '0;
                state_nxt    = WR1W;
            end
            WR1: begin
                bus.MMCM_RST = 1'b1;
                bus.DEN      = 1'b1;
                bus.DWE      = 1'b1;
                bus.DADDR    = REG1_ADDR;
                bus.DI       = reg1_new;
                cnt_nxt      = '0;
                state_nxt    = WD1;
            end
            RD2: begin
                bus.MMCM_RST = 1'b1;
                bus.DEN      = 1'b1;
                bus.DADDR    = REG2_ADDR;
                cnt_nxt      = '0;
                state_nxt    = WR2W;
            end
            WR2: begin
                bus.MMCM_RST = 1'b1;
                bus.DEN      = 1'b1;
                bus.DWE      = 1'b1;
                bus.DADDR    = REG2_ADDR;
                bus.DI       = reg2_new;
                cnt_nxt      = '0;
                state_nxt    = WD2;
            end
            // DRDY is only looked at here, so a DRDY coincident with DEN or outside a wait is dropped.
            WR1W, WD1, WR2W, WD2: begin
                bus.MMCM_RST = 1'b1;
                if (bus.DRDY) begin
                    if (state == WR1W || state == WR2W) rd_nxt = bus.DO;
                    state_nxt = wait_exit;
                end else if (cnt == DRDY_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RLS: begin
                cnt_nxt   = '0;
                state_nxt = LCK;
            end
            // LOCKED may still read high from before the reset; blank it for the first cycles.
            LCK: begin
                if (lock_s && cnt >= LOCK_BLANK) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == LOCK_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// Directed bench for mmcm_drp_sequencer with a behavioural DRP port and MMCM lock model.
module tb_mmcm_drp_sequencer;
    logic CLK_100 = 1'b0;
    logic RST;
    always #5 CLK_100 = ~CLK_100;

    mmcm_drp_sequencer_if bus();

    mmcm_drp_sequencer #(
        .REG1_ADDR    (7'h0C),
        .REG2_ADDR    (7'h0D),
        .DRDY_TIMEOUT (64),
        .LOCK_TIMEOUT (300)
    ) dut (
        .CLK_100 (CLK_100),
        .RST     (RST),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] rd1_val = 16'h0000, rd2_val = 16'h0000;
    logic [15:0] wr1_di = 16'h0000, wr2_di = 16'h0000;
    int den_cnt = 0, dwe_cnt = 0, rd1_cnt = 0, rd2_cnt = 0, stray_dwe = 0;
    int drdy_lat = 2;
    bit withhold_rd2 = 1'b0;
    int pend = 0;
    logic [15:0] pend_do = 16'h0000;
    int lock_mode = 0;   // 0: follows MMCM_RST, 1: stuck high, 2: never locks
    int lock_dly = 100;
    int lock_cnt = 0;

    // DRP slave: answers each DEN with one DRDY pulse drp_lat cycles later.
    initial begin
        bus.DRDY = 1'b0;
        bus.DO   = 16'h0000;
        forever begin
            @(posedge CLK_100); #1;
            bus.DRDY = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.DRDY = 1'b1;
                    bus.DO   = pend_do;
                end
            end
            if (bus.DWE === 1'b1 && bus.DEN !== 1'b1) stray_dwe++;
            if (bus.DEN === 1'b1) begin
                den_cnt++;
                if (bus.DWE === 1'b1) begin
                    dwe_cnt++;
                    if (bus.DADDR == 7'h0C) wr1_di = bus.DI;
                    else if (bus.DADDR == 7'h0D) wr2_di = bus.DI;
                    pend    = drdy_lat;
                    pend_do = 16'h0000;
                end else if (bus.DADDR == 7'h0C) begin
                    rd1_cnt++;
                    pend    = drdy_lat;
                    pend_do = rd1_val;
                end else if (bus.DADDR == 7'h0D) begin
                    rd2_cnt++;
                    if (!withhold_rd2) begin
                        pend    = drdy_lat;
                        pend_do = rd2_val;
                    end
                end
            end
        end
    end

    initial begin
        bus.LOCKED = 1'b0;
        forever begin
            @(posedge CLK_100); #1;
            if (lock_mode == 1) bus.LOCKED = 1'b1;
            else if (lock_mode == 2) bus.LOCKED = 1'b0;
            else if (bus.MMCM_RST === 1'b1) begin
                bus.LOCKED = 1'b0;
                lock_cnt   = 0;
            end else if (lock_cnt < lock_dly) lock_cnt++;
            else bus.LOCKED = 1'b1;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not reach its end, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic clear_counts();
        den_cnt = 0; dwe_cnt = 0; rd1_cnt = 0; rd2_cnt = 0;
        wr1_di = 16'hxxxx; wr2_di = 16'hxxxx;
    endtask

    task automatic pulse_req(input logic [5:0] d);
        @(negedge CLK_100);
        bus.REQ = 1'b1;
        bus.DIV = d;
        @(negedge CLK_100);
        bus.REQ = 1'b0;
    endtask

    task automatic wait_end(input int max, output int n, output bit dn, output bit er);
        dn = 1'b0; er = 1'b0; n = 0;
        while (n < max && !dn && !er) begin
            if (bus.DONE === 1'b1) dn = 1'b1;
            else if (bus.ERR === 1'b1) er = 1'b1;
            else begin
                @(negedge CLK_100);
                n++;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.REQ = 1'b0;
        bus.DIV = 6'd0;
        repeat (3) @(negedge CLK_100);
        checks++;
        if ({bus.BUSY, bus.DONE, bus.ERR, bus.DEN, bus.DWE, bus.MMCM_RST} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: BUSY/DONE/ERR/DEN/DWE/MMCM_RST=%b expected 000000",
                     {bus.BUSY, bus.DONE, bus.ERR, bus.DEN, bus.DWE, bus.MMCM_RST});
        end
        checks++;
        if ({bus.DADDR, bus.DI} !== 23'h0) begin
            errors++;
            $display("FAIL reset_bus: DADDR=%h DI=%h expected 00 0000", bus.DADDR, bus.DI);
        end
        RST = 1'b0;
        repeat (2) @(negedge CLK_100);
        checks++;
        if (bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: BUSY=%b expected 0", bus.BUSY);
        end
    endtask

    task automatic test_div6();
        int n; bit dn, er;
        rd1_val = 16'hFFFF; rd2_val = 16'h1234; drdy_lat = 2; lock_mode = 0;
        clear_counts();
        pulse_req(6'd6);
        checks++;
        if ({bus.BUSY, bus.MMCM_RST} !== 2'b11) begin
            errors++;
            $display("FAIL div6_start: BUSY,MMCM_RST=%b expected 11", {bus.BUSY, bus.MMCM_RST});
        end
        wait_end(800, n, dn, er);
        checks++;
        if (!dn || er) begin
            errors++;
            $display("FAIL div6_done: done=%b err=%b expected done=1 err=0", dn, er);
        end
        checks++;
        if (n < 100) begin
            errors++;
            $display("FAIL div6_lockwait: DONE after %0d cycles expected at least 100", n);
        end
        checks++;
        if ({bus.BUSY, bus.MMCM_RST} !== 2'b00) begin
            errors++;
            $display("FAIL div6_end: BUSY,MMCM_RST=%b expected 00", {bus.BUSY, bus.MMCM_RST});
        end
        checks++;
        if (wr1_di !== 16'h10C3) begin
            errors++;
            $display("FAIL div6_di1: got %h expected 10c3", wr1_di);
        end
        checks++;
        if (wr2_di !== 16'h1200) begin
            errors++;
            $display("FAIL div6_di2: got %h expected 1200", wr2_di);
        end
        @(negedge CLK_100);
        checks++;
        if (bus.DONE !== 1'b0) begin
            errors++;
            $display("FAIL div6_pulse: DONE=%b one cycle later expected 0", bus.DONE);
        end
    endtask

    task automatic test_div5();
        int n; bit dn, er;
        rd1_val = 16'hF5A5; rd2_val = 16'hABCD; drdy_lat = 1; lock_mode = 0;
        clear_counts();
        pulse_req(6'd5);
        wait_end(800, n, dn, er);
        checks++;
        if (!dn || er) begin
            errors++;
            $display("FAIL div5_done: done=%b err=%b expected done=1 err=0", dn, er);
        end
        checks++;
        if (wr1_di !== 16'h1083 || wr2_di !== 16'hAB80) begin
            errors++;
            $display("FAIL div5_di: got %h %h expected 1083 ab80", wr1_di, wr2_di);
        end
        checks++;
        if (den_cnt != 4 || dwe_cnt != 2 || rd1_cnt != 1 || rd2_cnt != 1) begin
            errors++;
            $display("FAIL div5_access: den=%0d dwe=%0d rd1=%0d rd2=%0d expected 4 2 1 1",
                     den_cnt, dwe_cnt, rd1_cnt, rd2_cnt);
        end
    endtask

    task automatic test_div1();
        int n; bit dn, er;
        rd1_val = 16'h0000; rd2_val = 16'h0000; drdy_lat = 3; lock_mode = 0;
        clear_counts();
        pulse_req(6'd1);
        wait_end(800, n, dn, er);
        checks++;
        if (!dn || wr1_di !== 16'h0001 || wr2_di !== 16'h00C0) begin
            errors++;
            $display("FAIL div1: done=%b di1=%h di2=%h expected 1 0001 00c0", dn, wr1_di, wr2_di);
        end
    endtask

    task automatic test_div0();
        clear_counts();
        pulse_req(6'd0);
        checks++;
        if ({bus.ERR, bus.BUSY} !== 2'b10) begin
            errors++;
            $display("FAIL div0_err: ERR,BUSY=%b expected 10", {bus.ERR, bus.BUSY});
        end
        @(negedge CLK_100);
        checks++;
        if (bus.ERR !== 1'b0) begin
            errors++;
            $display("FAIL div0_pulse: ERR=%b one cycle later expected 0", bus.ERR);
        end
        repeat (5) @(negedge CLK_100);
        checks++;
        if (den_cnt != 0 || bus.MMCM_RST !== 1'b0 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL div0_quiet: den=%0d MMCM_RST=%b BUSY=%b expected 0 0 0",
                     den_cnt, bus.MMCM_RST, bus.BUSY);
        end
    endtask

    task automatic test_drdy_timeout();
        int t0, t1, n; bit dn, er;
        rd1_val = 16'h0000; rd2_val = 16'h0000; drdy_lat = 2; lock_mode = 0;
        withhold_rd2 = 1'b1;
        clear_counts();
        t0 = -1000; t1 = -1;
        pulse_req(6'd7);
        for (int i = 0; i < 300; i++) begin
            if (bus.DEN === 1'b1 && bus.DWE === 1'b0 && bus.DADDR == 7'h0D) t0 = i;
            if (bus.ERR === 1'b1) begin
                t1 = i;
                break;
            end
            @(negedge CLK_100);
        end
        // RD2 DEN, then 64 unanswered wait cycles, then the registered ERR.
        checks++;
        if (t1 < 0 || t1 - t0 != 65) begin
            errors++;
            $display("FAIL drdy_timeout: ERR %0d cycles after RD2 DEN (seen=%0d) expected 65",
                     t1 - t0, t1 >= 0);
        end
        checks++;
        if ({bus.MMCM_RST, bus.BUSY} !== 2'b00) begin
            errors++;
            $display("FAIL drdy_timeout_state: MMCM_RST,BUSY=%b expected 00", {bus.MMCM_RST, bus.BUSY});
        end
        withhold_rd2 = 1'b0;
        repeat (3) @(negedge CLK_100);
        clear_counts();
        pulse_req(6'd9);
        wait_end(800, n, dn, er);
        checks++;
        if (!dn || er || wr1_di !== 16'h0105 || wr2_di !== 16'h0080) begin
            errors++;
            $display("FAIL drdy_retry: done=%b err=%b di1=%h di2=%h expected 1 0 0105 0080",
                     dn, er, wr1_di, wr2_di);
        end
    endtask

    task automatic test_lock_stale();
        int tr, td; logic prev;
        lock_mode = 1; drdy_lat = 1;
        repeat (4) @(negedge CLK_100);
        tr = -1000; td = -1;
        pulse_req(6'd4);
        prev = bus.MMCM_RST;
        for (int i = 0; i < 300; i++) begin
            if (prev === 1'b1 && bus.MMCM_RST === 1'b0) tr = i;
            prev = bus.MMCM_RST;
            if (bus.DONE === 1'b1) begin
                td = i;
                break;
            end
            @(negedge CLK_100);
        end
        // RLS, four blanked LCK cycles, the accepting LCK cycle, then DONE.
        checks++;
        if (td < 0 || td - tr != 6) begin
            errors++;
            $display("FAIL lock_stale: DONE %0d cycles after MMCM_RST release (seen=%0d) expected 6",
                     td - tr, td >= 0);
        end
    endtask

    task automatic test_lock_timeout();
        int tr, te; logic prev;
        lock_mode = 2; drdy_lat = 1;
        repeat (4) @(negedge CLK_100);
        tr = -1000; te = -1;
        pulse_req(6'd10);
        prev = bus.MMCM_RST;
        for (int i = 0; i < 800; i++) begin
            if (prev === 1'b1 && bus.MMCM_RST === 1'b0) tr = i;
            prev = bus.MMCM_RST;
            if (bus.DONE === 1'b1) break;
            if (bus.ERR === 1'b1) begin
                te = i;
                break;
            end
            @(negedge CLK_100);
        end
        checks++;
        if (te < 0 || te - tr != 301) begin
            errors++;
            $display("FAIL lock_timeout: ERR %0d cycles after MMCM_RST release (seen=%0d) expected 301",
                     te - tr, te >= 0);
        end
        checks++;
        if ({bus.BUSY, bus.MMCM_RST, bus.DONE} !== 3'b000) begin
            errors++;
            $display("FAIL lock_timeout_state: BUSY,MMCM_RST,DONE=%b expected 000",
                     {bus.BUSY, bus.MMCM_RST, bus.DONE});
        end
        lock_mode = 0;
    endtask

    task automatic test_req_while_busy();
        int n; bit dn, er;
        rd1_val = 16'h0000; rd2_val = 16'h0000; drdy_lat = 2; lock_mode = 0;
        clear_counts();
        pulse_req(6'd6);
        repeat (3) @(negedge CLK_100);
        pulse_req(6'd0);
        checks++;
        if (bus.ERR !== 1'b0 || bus.BUSY !== 1'b1) begin
            errors++;
            $display("FAIL busy_req0: ERR=%b BUSY=%b expected 0 1", bus.ERR, bus.BUSY);
        end
        pulse_req(6'd12);
        wait_end(800, n, dn, er);
        checks++;
        if (!dn || er || den_cnt != 4 || wr1_di !== 16'h00C3) begin
            errors++;
            $display("FAIL busy_req: done=%b err=%b den=%0d di1=%h expected 1 0 4 00c3",
                     dn, er, den_cnt, wr1_di);
        end
    endtask

    task automatic test_rst_mid();
        int n; bit dn, er, found, pulses;
        rd1_val = 16'h0000; rd2_val = 16'h0000; drdy_lat = 3; lock_mode = 0;
        clear_counts();
        found = 1'b0;
        pulse_req(6'd8);
        for (int i = 0; i < 50; i++) begin
            if (bus.DEN === 1'b1 && bus.DWE === 1'b1 && bus.DADDR == 7'h0C) begin
                found = 1'b1;
                break;
            end
            @(negedge CLK_100);
        end
        @(negedge CLK_100);
        RST = 1'b1;
        #1;
        checks++;
        if (!found || {bus.BUSY, bus.MMCM_RST} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_ctrl: found_wr1=%b BUSY,MMCM_RST=%b expected 1 00",
                     found, {bus.BUSY, bus.MMCM_RST});
        end
        checks++;
        if ({bus.DONE, bus.ERR, bus.DEN, bus.DWE, bus.DADDR, bus.DI} !== 27'h0) begin
            errors++;
            $display("FAIL rst_mid_bus: DONE=%b ERR=%b DEN=%b DWE=%b DADDR=%h DI=%h expected all 0",
                     bus.DONE, bus.ERR, bus.DEN, bus.DWE, bus.DADDR, bus.DI);
        end
        repeat (3) @(negedge CLK_100);
        RST = 1'b0;
        pulses = 1'b0;
        repeat (8) begin
            @(negedge CLK_100);
            if (bus.DONE === 1'b1 || bus.ERR === 1'b1) pulses = 1'b1;
        end
        checks++;
        if (pulses) begin
            errors++;
            $display("FAIL rst_mid_quiet: DONE or ERR pulsed after reset, expected none");
        end
        clear_counts();
        pulse_req(6'd8);
        wait_end(800, n, dn, er);
        checks++;
        if (!dn || er || wr1_di !== 16'h0104 || wr2_di !== 16'h0000) begin
            errors++;
            $display("FAIL rst_mid_retry: done=%b err=%b di1=%h di2=%h expected 1 0 0104 0000",
                     dn, er, wr1_di, wr2_di);
        end
    endtask

    initial begin
        test_reset();
        test_div6();
        test_div5();
        test_div1();
        test_div0();
        test_drdy_timeout();
        test_lock_stale();
        test_lock_timeout();
        test_req_while_busy();
        test_rst_mid();
        checks++;
        if (stray_dwe != 0) begin
            errors++;
            $display("FAIL dwe_without_den: %0d cycles expected 0", stray_dwe);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
